// File: rtl/gp_cmd_dispatch.sv
// Graphics-processor command dispatcher: queues CPU command pushes, issues them one at a time
// and raises frame_interrupt per completed or watchdog-aborted list. Optional macro: GP_VSYNC_EN.
module gp_cmd_dispatch #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 1 << 20,
  parameter int unsigned CNT_W   = 21
) (
  input  logic        clk,
  input  logic        rst,
`ifdef GP_VSYNC_EN
  input  logic        vsync,
`endif
  input  logic [31:0] gp_code,
  input  logic [31:0] gp_frame,
  input  logic        gp_valid,
  output logic [31:0] cmd_addr,
  output logic [31:0] frame_base,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  input  logic        gp_done,
  output logic        frame_interrupt,
  output logic        busy,
  output logic [4:0]  level,
  output logic        overflow,
  output logic        timeout_err
);

  localparam int unsigned      AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0]       DEPTH_L = 5'(DEPTH);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);
  localparam bit               WD_EN   = (TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE, ISSUE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [63:0]      fifoMem [DEPTH];
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [4:0]       level_q, level_d;
  logic [31:0]      cmdAddr_q, cmdAddr_d;
  logic [31:0]      frameBase_q, frameBase_d;
  logic [CNT_W-1:0] wdog_q, wdog_d;
  logic             overflow_q, overflow_d;
  logic             timeoutErr_q, timeoutErr_d;
  logic             popGate;
  logic             doPop;
  logic             doPush;
  logic [63:0]      headEntry;

`ifdef GP_VSYNC_EN
  assign popGate = vsync;
`else
  assign popGate = 1'b1;
`endif

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign doPop     = (state_q == IDLE) && (level_q != 5'd0) && popGate;
  assign doPush    = gp_valid && ((level_q < DEPTH_L) || doPop);
  assign headEntry = fifoMem[rdPtr_q];

  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    level_d    = level_q;
    overflow_d = overflow_q | (gp_valid & ~doPush);
    if (doPush) wrPtr_d = wrPtr_q + AW'(1);
    if (doPop)  rdPtr_d = rdPtr_q + AW'(1);
    case ({doPush, doPop})
      2'b10:   level_d = level_q + 5'd1;
      2'b01:   level_d = level_q - 5'd1;
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cmdAddr_d    = cmdAddr_q;
    frameBase_d  = frameBase_q;
    wdog_d       = wdog_q;
    timeoutErr_d = timeoutErr_q;
    case (state_q)
      IDLE: begin
        if (doPop) begin
          state_d     = ISSUE;
          cmdAddr_d   = headEntry[63:32];
          frameBase_d = headEntry[31:0];
        end
      end
      ISSUE: begin
        if (cmd_ready) begin
          state_d = RUN;
          wdog_d  = '0;
        end
      end
      RUN: begin
        // Completion wins over a watchdog expiry landing in the same cycle.
        if (gp_done) begin
          state_d = DONE;
        end else if (WD_EN && (wdog_q == WD_LAST)) begin
          state_d      = DONE;
          timeoutErr_d = 1'b1;
        end else begin
          wdog_d = wdog_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      level_q      <= '0;
      cmdAddr_q    <= '0;
      frameBase_q  <= '0;
      wdog_q       <= '0;
      overflow_q   <= 1'b0;
      timeoutErr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wrPtr_q      <= wrPtr_d;
      rdPtr_q      <= rdPtr_d;
      level_q      <= level_d;
      cmdAddr_q    <= cmdAddr_d;
      frameBase_q  <= frameBase_d;
      wdog_q       <= wdog_d;
      overflow_q   <= overflow_d;
      timeoutErr_q <= timeoutErr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) fifoMem[wrPtr_q] <= {gp_code, gp_frame};
  end

  assign cmd_addr        = cmdAddr_q;
  assign frame_base      = frameBase_q;
  assign cmd_valid       = (state_q == ISSUE);
  assign frame_interrupt = (state_q == DONE);
  assign busy            = (state_q != IDLE) || (level_q != 5'd0);
  assign level           = level_q;
  assign overflow        = overflow_q;
  assign timeout_err     = timeoutErr_q;

endmodule

// File: tb/tb_gp_cmd_dispatch.sv
// Self-checking bench for gp_cmd_dispatch (default build, DEPTH=4, TIMEOUT=16).
// Issued commands are scored against a queue filled when each push is driven.
module tb_gp_cmd_dispatch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] gp_code;
  logic [31:0] gp_frame;
  logic        gp_valid;
  logic [31:0] cmd_addr;
  logic [31:0] frame_base;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        gp_done;
  logic        frame_interrupt;
  logic        busy;
  logic [4:0]  level;
  logic        overflow;
  logic        timeout_err;

  int          checkCount = 0;
  int          passCount  = 0;
  int          intrCount  = 0;
  int          intrBefore = 0;
  logic [63:0] expQ [$];

  gp_cmd_dispatch #(.DEPTH(4), .TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .gp_code(gp_code), .gp_frame(gp_frame), .gp_valid(gp_valid),
    .cmd_addr(cmd_addr), .frame_base(frame_base), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .gp_done(gp_done), .frame_interrupt(frame_interrupt), .busy(busy), .level(level),
    .overflow(overflow), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] code, input logic [31:0] frame, input bit expectAccept);
    gp_code  = code;
    gp_frame = frame;
    gp_valid = 1'b1;
    if (expectAccept) expQ.push_back({code, frame});
    tick(1);
    gp_valid = 1'b0;
  endtask

  task automatic pulseDone();
    gp_done = 1'b1;
    tick(1);
    gp_done = 1'b0;
  endtask

  task automatic waitValid();
    int n = 0;
    while (!cmd_valid && n < 30) begin
      tick(1);
      n++;
    end
    checkOutput("cmdValidWait", 64'(cmd_valid), 64'd1);
  endtask

  // Score every handshake transfer and count interrupt pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_valid && cmd_ready) begin
        if (expQ.size() == 0) checkOutput("xferUnexpected", 64'd1, 64'd0);
        else checkOutput("xferPayload", {cmd_addr, frame_base}, expQ.pop_front());
      end
      if (frame_interrupt) intrCount++;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL globalTimeout: simulation did not finish, expected finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    rst = 1'b1; gp_code = '0; gp_frame = '0; gp_valid = 1'b0; cmd_ready = 1'b0; gp_done = 1'b0;
    tick(2);
    checkOutput("rstCmdValid", 64'(cmd_valid), 64'd0);
    checkOutput("rstAddr", {cmd_addr, frame_base}, 64'd0);
    checkOutput("rstLevel", 64'(level), 64'd0);
    checkOutput("rstFlags", {60'd0, busy, overflow, timeout_err, frame_interrupt}, 64'd0);
    rst = 1'b0;
    tick(1);

    // Basic command: two-cycle latency, single interrupt, idle afterwards.
    cmd_ready = 1'b1;
    applyStimulus(32'h100, 32'h1F00_0000, 1'b1);
    checkOutput("lat1CmdValid", 64'(cmd_valid), 64'd0);
    checkOutput("lat1Level", 64'(level), 64'd1);
    tick(1);
    checkOutput("lat2CmdValid", 64'(cmd_valid), 64'd1);
    checkOutput("lat2Payload", {cmd_addr, frame_base}, 64'h0000_0100_1F00_0000);
    checkOutput("lat2Level", 64'(level), 64'd0);
    tick(1);
    checkOutput("runCmdValid", 64'(cmd_valid), 64'd0);
    checkOutput("runBusy", 64'(busy), 64'd1);
    tick(9);
    pulseDone();
    checkOutput("doneIntr", 64'(frame_interrupt), 64'd1);
    tick(1);
    checkOutput("intrOneCycle", 64'(frame_interrupt), 64'd0);
    checkOutput("idleBusy", 64'(busy), 64'd0);

    // gp_done while idle is ignored.
    pulseDone();
    checkOutput("strayDoneIntr", 64'(frame_interrupt), 64'd0);

    // Backpressure: command held stable until the GP accepts it.
    cmd_ready = 1'b0;
    applyStimulus(32'h200, 32'h2F00_0000, 1'b1);
    tick(1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stallValid", 64'(cmd_valid), 64'd1);
      checkOutput("stallPayload", {cmd_addr, frame_base}, 64'h0000_0200_2F00_0000);
      tick(1);
    end
    cmd_ready = 1'b1;
    tick(1);
    checkOutput("afterReadyValid", 64'(cmd_valid), 64'd0);
    pulseDone();
    checkOutput("stallIntr", 64'(frame_interrupt), 64'd1);
    tick(1);

    // Overflow: GP busy, six pushes into a four-entry FIFO.
    applyStimulus(32'h300, 32'h3F00_0000, 1'b1);
    tick(2);
    checkOutput("ovfRunValid", 64'(cmd_valid), 64'd0);
    for (int k = 0; k < 6; k++)
      applyStimulus(32'h400 + 32'(k) * 32'h10, 32'h4000_0000 + 32'(k), k < 4);
    checkOutput("ovfLevel", 64'(level), 64'd4);
    checkOutput("ovfFlag", 64'(overflow), 64'd1);
    pulseDone();
    checkOutput("ovfIntr", 64'(frame_interrupt), 64'd1);
    for (int k = 0; k < 4; k++) begin
      waitValid();
      tick(1);
      pulseDone();
      checkOutput("drainIntr", 64'(frame_interrupt), 64'd1);
    end
    tick(1);
    checkOutput("drainLevel", 64'(level), 64'd0);
    checkOutput("ovfSticky", 64'(overflow), 64'd1);

    // gp_done on the final watchdog cycle counts as completion.
    applyStimulus(32'h500, 32'h5F00_0000, 1'b1);
    waitValid();
    tick(1);
    tick(15);
    pulseDone();
    checkOutput("edgeIntr", 64'(frame_interrupt), 64'd1);
    checkOutput("edgeNoErr", 64'(timeout_err), 64'd0);
    tick(1);

    // Watchdog abort after 16 RUN cycles; queued command follows.
    applyStimulus(32'h600, 32'h6F00_0000, 1'b1);
    waitValid();
    tick(1);
    applyStimulus(32'h700, 32'h7F00_0000, 1'b1);
    tick(14);
    checkOutput("preTmoErr", 64'(timeout_err), 64'd0);
    checkOutput("preTmoIntr", 64'(frame_interrupt), 64'd0);
    tick(1);
    checkOutput("tmoIntr", 64'(frame_interrupt), 64'd1);
    checkOutput("tmoErr", 64'(timeout_err), 64'd1);
    tick(1);
    checkOutput("tmoIdleValid", 64'(cmd_valid), 64'd0);
    tick(1);
    checkOutput("tmoNextValid", 64'(cmd_valid), 64'd1);
    tick(1);
    pulseDone();
    checkOutput("tmoNextIntr", 64'(frame_interrupt), 64'd1);
    tick(1);

    // Reset mid-RUN with two commands queued.
    applyStimulus(32'h800, 32'h8F00_0000, 1'b1);
    waitValid();
    tick(1);
    applyStimulus(32'h900, 32'h9F00_0000, 1'b1);
    applyStimulus(32'hA00, 32'hAF00_0000, 1'b1);
    checkOutput("preRstLevel", 64'(level), 64'd2);
    rst = 1'b1;
    #1;
    checkOutput("midRstValid", 64'(cmd_valid), 64'd0);
    checkOutput("midRstAddr", {cmd_addr, frame_base}, 64'd0);
    checkOutput("midRstLevel", 64'(level), 64'd0);
    checkOutput("midRstFlags", {60'd0, busy, overflow, timeout_err, frame_interrupt}, 64'd0);
    expQ.delete();
    intrBefore = intrCount;
    tick(3);
    rst = 1'b0;
    tick(3);
    checkOutput("rstNoIntr", 64'(intrCount), 64'(intrBefore));
    checkOutput("rstIdleValid", 64'(cmd_valid), 64'd0);
    checkOutput("rstIdleBusy", 64'(busy), 64'd0);

    checkOutput("queueDrained", 64'(expQ.size()), 64'd0);
    checkOutput("intrTotal", 64'(intrCount), 64'd10);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
